// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared widths, fetch FSM encoding and PC helpers for if_stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int ADDR_W           = 32;
    localparam int INST_W           = 32;
    localparam int ICACHE_LINES_DEF = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [2:0]        off);
        return base + {{(ADDR_W-3){1'b0}}, off};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if.sv
// ============================================================================
// Module  : if_stage_if
// Brief   : Control, RAM-port and if_id-facing signals of the fetch stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
    import if_stage_pkg::*;

    logic              stall_i;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              mem_busy_i;
    logic [7:0]        ram_data_i;
    logic              ram_rd_en_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              inst_valid_o;

    modport master (
        input  stall_i, jump_flag_i, jump_addr_i, mem_busy_i, ram_data_i,
        output ram_rd_en_o, ram_addr_o, pc_o, inst_o, inst_valid_o
    );

    modport slave (
        output stall_i, jump_flag_i, jump_addr_i, mem_busy_i, ram_data_i,
        input  ram_rd_en_o, ram_addr_o, pc_o, inst_o, inst_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/if_stage_icache.sv
// ============================================================================
// Module  : if_stage_icache
// Brief   : Direct-mapped one-word-per-line instruction cache, async lookup.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage_icache
    import if_stage_pkg::*;
#(
    parameter int LINES   = ICACHE_LINES_DEF,
    parameter int INDEX_W = $clog2(LINES)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [ADDR_W-1:2] rd_word,
    output logic                   hit,
    output logic [INST_W-1:0]      rd_data,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:2] wr_word,
    input  wire logic [INST_W-1:0] wr_data
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [INST_W-1:0] data [LINES];

    logic [INDEX_W-1:0] rd_idx;
    logic [INDEX_W-1:0] wr_idx;

    assign rd_idx  = rd_word[INDEX_W+1:2];
    assign wr_idx  = wr_word[INDEX_W+1:2];
    assign hit     = valid[rd_idx] && (tags[rd_idx] == rd_word[ADDR_W-1:INDEX_W+2]);
    assign rd_data = data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_word[ADDR_W-1:INDEX_W+2];
            data[wr_idx] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module  : if_stage
// Brief   : RV32I fetch stage: PC, byte-wise RAM fill, direct-mapped icache.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0,
    parameter int                ICACHE_LINES = ICACHE_LINES_DEF,
    parameter int                INDEX_W      = $clog2(ICACHE_LINES)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    if_stage_if.master  bus
);

    fetch_state_t      state, state_n;
    logic [2:0]        iss, iss_n;
    logic [1:0]        rcv, rcv_n;
    logic [23:0]       bytes_q, bytes_n;
    logic              issued, issued_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [INST_W-1:0] inst, inst_n;
    logic              valid, valid_n;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              fill_we;
    logic [INST_W-1:0] fill_word;
    logic              hit;
    logic [INST_W-1:0] hit_data;

    assign fill_word = {bus.ram_data_i, bytes_q};

    if_stage_icache #(
        .LINES   (ICACHE_LINES),
        .INDEX_W (INDEX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc[ADDR_W-1:2]),
        .hit     (hit),
        .rd_data (hit_data),
        .wr_en   (fill_we),
        .wr_word (pc[ADDR_W-1:2]),
        .wr_data (fill_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            iss     <= '0;
            rcv     <= '0;
            bytes_q <= '0;
            issued  <= 1'b0;
            pc      <= RESET_PC;
            inst    <= '0;
            valid   <= 1'b0;
        end else begin
            state   <= state_n;
            iss     <= iss_n;
            rcv     <= rcv_n;
            bytes_q <= bytes_n;
            issued  <= issued_n;
            pc      <= pc_n;
            inst    <= inst_n;
            valid   <= valid_n;
        end
    end

    always_comb begin
        state_n  = state;
        iss_n    = iss;
        rcv_n    = rcv;
        bytes_n  = bytes_q;
        pc_n     = pc;
        inst_n   = inst;
        valid_n  = valid;
        fill_we  = 1'b0;
        rd_en    = (state == FETCH) && (iss < 3'd4) && !bus.mem_busy_i;
        rd_addr  = rd_en ? byte_addr(pc, iss) : '0;
        issued_n = rd_en;

        case (state)
            IDLE: begin
                if (!valid) begin
                    if (hit) begin
                        inst_n  = hit_data;
                        valid_n = 1'b1;
                    end else begin
                        state_n = FETCH;
                        iss_n   = '0;
                        rcv_n   = '0;
                    end
                end
            end
            FETCH: begin
                if (rd_en) begin
                    iss_n = iss + 3'd1;
                end
                // A byte issued last cycle is captured even if this cycle is busy.
                if (issued) begin
                    rcv_n = rcv + 2'd1;
                    case (rcv)
                        2'd0:    bytes_n[7:0]   = bus.ram_data_i;
                        2'd1:    bytes_n[15:8]  = bus.ram_data_i;
                        2'd2:    bytes_n[23:16] = bus.ram_data_i;
                        default: begin
                            fill_we = 1'b1;
                            inst_n  = fill_word;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

        if (valid && !bus.stall_i && !bus.jump_flag_i) begin
            pc_n    = next_pc(pc);
            valid_n = 1'b0;
        end

        // Redirect aborts any fill; partial bytes never reach the cache.
        if (!bus.stall_i && bus.jump_flag_i) begin
            pc_n     = bus.jump_addr_i;
            valid_n  = 1'b0;
            state_n  = IDLE;
            iss_n    = '0;
            rcv_n    = '0;
            issued_n = 1'b0;
            fill_we  = 1'b0;
        end

        if (rst) begin
            fill_we = 1'b0;
        end
    end

    assign bus.ram_rd_en_o  = rd_en;
    assign bus.ram_addr_o   = rd_addr;
    assign bus.pc_o         = pc;
    assign bus.inst_o       = inst;
    assign bus.inst_valid_o = valid;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module  : tb_if_stage
// Brief   : Directed self-checking bench for if_stage with a byte RAM model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_stage;
    import if_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   lat;

    logic [7:0]  mem [4096];
    logic [31:0] addr_q [$];

    if_stage_if bus ();

    if_stage #(
        .RESET_PC     (32'h0),
        .ICACHE_LINES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read byte RAM plus a log of every issued address.
    always @(posedge clk) begin
        if (bus.ram_rd_en_o) begin
            addr_q.push_back(bus.ram_addr_o);
            bus.ram_data_i <= mem[bus.ram_addr_o[11:0]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the lookup cycle; mem_busy_i is high for cycles bfrom..bto.
    task automatic wait_valid(input int bfrom, input int bto, output int l);
        l = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.mem_busy_i = (c >= bfrom) && (c <= bto);
            tick();
            if (bus.inst_valid_o) begin
                l = c;
                break;
            end
        end
        bus.mem_busy_i = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = a;
        tick();
        bus.jump_flag_i = 1'b0;
        addr_q.delete();
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] exp [6], input int n);
        check_val({tag, "_count"}, 32'(addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < addr_q.size(); i++) begin
            check_val(tag, addr_q[i], exp[i]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus.stall_i     = 1'b0;
        bus.jump_flag_i = 1'b0;
        bus.jump_addr_i = '0;
        bus.mem_busy_i  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h000] = 8'h13; mem[12'h001] = 8'h05; mem[12'h002] = 8'h10; mem[12'h003] = 8'h00;
        mem[12'h040] = 8'h93; mem[12'h041] = 8'h00; mem[12'h042] = 8'h10; mem[12'h043] = 8'h00;
        mem[12'h080] = 8'haa; mem[12'h081] = 8'hbb; mem[12'h082] = 8'hcc; mem[12'h083] = 8'hdd;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'hffe] = 8'h5a; mem[12'hfff] = 8'ha5;

        // Reset state
        tick();
        tick();
        check_val("rst_pc",    bus.pc_o,                0);
        check_val("rst_inst",  bus.inst_o,              0);
        check_val("rst_valid", 32'(bus.inst_valid_o),   0);
        check_val("rst_rd_en", 32'(bus.ram_rd_en_o),    0);
        check_val("rst_addr",  bus.ram_addr_o,          0);

        // Cold miss at 0: 6-cycle latency
        addr_q.delete();
        rst = 1'b0;
        wait_valid(0, 0, lat);
        check_val("s1_lat",  32'(lat),   6);
        check_val("s1_inst", bus.inst_o, 32'h00100513);
        check_val("s1_pc",   bus.pc_o,   0);
        check_addrs("s1_addr", '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0}, 4);

        // Consume, then redirect back to 0: hit in 1 cycle
        tick();
        check_val("s2_cons_pc",    bus.pc_o,              4);
        check_val("s2_cons_valid", 32'(bus.inst_valid_o), 0);
        jump_to(32'h0);
        check_val("s2_jump_pc",    bus.pc_o,              0);
        wait_valid(0, 0, lat);
        check_val("s2_lat",  32'(lat),   1);
        check_val("s2_inst", bus.inst_o, 32'h00100513);
        check_addrs("s2_addr", '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0);

        // Miss with 3 busy cycles after byte 1 issues
        jump_to(32'h80);
        wait_valid(4, 6, lat);
        check_val("s3_lat",  32'(lat),   9);
        check_val("s3_inst", bus.inst_o, 32'hddccbbaa);
        check_addrs("s3_addr", '{32'h80, 32'h81, 32'h82, 32'h83, 32'h0, 32'h0}, 4);

        // Abort a fill at 0x40 after two issues
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h40;
        tick();
        bus.jump_flag_i = 1'b0;
        addr_q.delete();
        tick();
        tick();
        check_val("s4_rd_en_mid", 32'(bus.ram_rd_en_o), 1);
        bus.jump_flag_i = 1'b1;
        bus.jump_addr_i = 32'h100;
        tick();
        bus.jump_flag_i = 1'b0;
        check_val("s4_jump_pc", bus.pc_o, 32'h100);
        wait_valid(0, 0, lat);
        check_val("s4_lat",  32'(lat),   6);
        check_val("s4_inst", bus.inst_o, 32'h44332211);
        check_val("s4_pc",   bus.pc_o,   32'h100);
        check_addrs("s4_addr", '{32'h40, 32'h41, 32'h100, 32'h101, 32'h102, 32'h103}, 6);
        jump_to(32'h40);
        wait_valid(0, 0, lat);
        check_val("s4_refetch_lat",  32'(lat),   6);
        check_val("s4_refetch_inst", bus.inst_o, 32'h00100093);
        check_addrs("s4_refetch_addr", '{32'h40, 32'h41, 32'h42, 32'h43, 32'h0, 32'h0}, 4);

        // Stall holds outputs; a jump during stall is ignored
        bus.jump_addr_i = 32'h300;
        for (int s = 0; s < 4; s++) begin
            bus.stall_i     = 1'b1;
            bus.jump_flag_i = (s == 1);
            tick();
            check_val("s5_pc",    bus.pc_o,              32'h40);
            check_val("s5_inst",  bus.inst_o,            32'h00100093);
            check_val("s5_valid", 32'(bus.inst_valid_o), 1);
        end
        bus.jump_flag_i = 1'b0;
        bus.stall_i     = 1'b0;
        tick();
        check_val("s5_cons_pc",    bus.pc_o,              32'h44);
        check_val("s5_cons_valid", 32'(bus.inst_valid_o), 0);

        // Index 0 conflict: 0x0 and 0x100 evict each other
        jump_to(32'h0);
        wait_valid(0, 0, lat);
        check_val("s6_a_lat", 32'(lat), 6);
        jump_to(32'h100);
        wait_valid(0, 0, lat);
        check_val("s6_b_lat",  32'(lat),   6);
        check_val("s6_b_inst", bus.inst_o, 32'h44332211);
        jump_to(32'h0);
        wait_valid(0, 0, lat);
        check_val("s6_c_lat",  32'(lat),   6);
        check_val("s6_c_inst", bus.inst_o, 32'h00100513);
        check_addrs("s6_c_addr", '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0}, 4);
        jump_to(32'h40);
        wait_valid(0, 0, lat);
        check_val("s6_d_hit_lat", 32'(lat), 1);

        // Address wrap at the top of the 32-bit space
        jump_to(32'hffff_fffe);
        wait_valid(0, 0, lat);
        check_val("s7_lat",  32'(lat),   6);
        check_val("s7_inst", bus.inst_o, 32'h0513a55a);
        check_addrs("s7_addr", '{32'hffff_fffe, 32'hffff_ffff, 32'h0, 32'h1, 32'h0, 32'h0}, 4);
        tick();
        check_val("s7_wrap_pc", bus.pc_o, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
